// File: rtl/cfg_logic_tile.sv
`default_nettype none
// ============================================================================
//  Module      : cfg_logic_tile
//  Description : Serially configured K-input LUT tile. Configuration is
//                shifted in LSB first through a daisy-chainable scan chain
//                under a small load state machine. The output is either the
//                raw LUT value or a clock-enabled flip-flop with an init value.
//  Revision    : 1.0  initial release
// ============================================================================
module cfg_logic_tile #(
   parameter int K = 5
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         cfg_en,
   input  logic         cfg_in,
   output logic         cfg_out,
   output logic         cfg_done,
   input  logic [K-1:0] in,
   input  logic         ce,
   output logic         out
);

   localparam int LUT_N = 1 << K;
   localparam int CFG_W = LUT_N + 2;
   localparam int CNT_W = $clog2(CFG_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      UNCONFIG = 2'd0,
      LOAD     = 2'd1,
      ACTIVE   = 2'd2
   } state_t;

   state_t             state;
   logic [CFG_W-1:0]   cfg;
   logic [CNT_W-1:0]   count;
   logic               q;
   logic [LUT_N-1:0]   lut;
   logic               mode;
   logic               d;

   // Truth table and mode bit are views into the configuration register;
   // the init bit is consumed directly from cfg_in on the completing edge.
   assign lut     = cfg[LUT_N-1:0];
   assign mode    = cfg[LUT_N];
   assign d       = lut[in];
   assign cfg_out = cfg[0];

   // Scan chain: one bit enters at the top on every enabled edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cfg <= '0;
      end else if (cfg_en) begin
         cfg <= {cfg_in, cfg[CFG_W-1:1]};
      end
   end

   // Load state machine with bit counter, output flip-flop and done flag.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= UNCONFIG;
         count    <= '0;
         q        <= 1'b0;
         cfg_done <= 1'b0;
      end else begin
         case (state)
            UNCONFIG: begin
               q <= 1'b0;
               if (cfg_en) begin
                  state <= LOAD;
                  count <= CNT_ONE;
               end
            end
            LOAD: begin
               if (cfg_en) begin
                  if (count == CNT_LAST) begin
                     // Final bit of the frame: it is also the init value.
                     state    <= ACTIVE;
                     count    <= '0;
                     q        <= cfg_in;
                     cfg_done <= 1'b1;
                  end else begin
                     count <= count + CNT_ONE;
                     q     <= 1'b0;
                  end
               end else begin
                  q <= 1'b0;
               end
            end
            ACTIVE: begin
               if (cfg_en) begin
                  // Reconfiguration takes priority over the clock enable.
                  state    <= LOAD;
                  count    <= CNT_ONE;
                  q        <= 1'b0;
                  cfg_done <= 1'b0;
               end else if (ce) begin
                  q <= d;
               end
            end
            default: begin
               state    <= UNCONFIG;
               count    <= '0;
               q        <= 1'b0;
               cfg_done <= 1'b0;
            end
         endcase
      end
   end

   // Output select: forced low until configured, then LUT or flip-flop.
   always_comb begin
      out = 1'b0;
      if (state == ACTIVE) begin
         out = mode ? q : d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cfg_logic_tile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cfg_logic_tile
//  Description : Self-checking bench for cfg_logic_tile with K=2 (CFG_W=6).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cfg_logic_tile;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       cfg_en = 1'b0;
   logic       cfg_in = 1'b0;
   logic       cfg_out;
   logic       cfg_done;
   logic [1:0] tin = 2'b00;
   logic       ce = 1'b0;
   logic       out;

   logic       ch_en = 1'b0;
   logic       ch_in = 1'b0;
   logic       ch_ce = 1'b0;
   logic [1:0] ch_sel = 2'b00;
   logic       a_cfg_out, a_done, a_out;
   logic       b_cfg_out, b_done, b_out;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [1:0] a;
      logic       ce;
      logic       exp;
   } vec_t;

   typedef struct {
      string name;
      logic  exp;
   } sb_t;

   sb_t  sbq[$];
   vec_t xor_vec[4];
   vec_t and_vec[8];

   logic [5:0] xor_f  = 6'b000110;  // comb, init 0
   logic [5:0] and_f  = 6'b111000;  // registered, init 1
   logic [5:0] nand_f = 6'b100111;  // comb, init 1

   cfg_logic_tile #(.K(2)) dut (
      .clock(clock), .reset_n(reset_n), .cfg_en(cfg_en), .cfg_in(cfg_in),
      .cfg_out(cfg_out), .cfg_done(cfg_done), .in(tin), .ce(ce), .out(out)
   );

   cfg_logic_tile #(.K(2)) tile_a (
      .clock(clock), .reset_n(reset_n), .cfg_en(ch_en), .cfg_in(ch_in),
      .cfg_out(a_cfg_out), .cfg_done(a_done), .in(ch_sel), .ce(ch_ce), .out(a_out)
   );

   cfg_logic_tile #(.K(2)) tile_b (
      .clock(clock), .reset_n(reset_n), .cfg_en(ch_en), .cfg_in(a_cfg_out),
      .cfg_out(b_cfg_out), .cfg_done(b_done), .in(ch_sel), .ce(ch_ce), .out(b_out)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic pop_check(input logic act);
      sb_t item;
      if (sbq.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_empty: got no entry expected one");
      end else begin
         item = sbq.pop_front();
         check(item.name, act, item.exp);
      end
   endtask

   task automatic shift1(input logic b);
      cfg_en = 1'b1;
      cfg_in = b;
      tick();
      cfg_en = 1'b0;
      cfg_in = 1'b0;
   endtask

   // Shift frame bits first..last, checking done/out after every edge.
   task automatic load_bits(input logic [5:0] f, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         shift1(f[i]);
         check("load_done", cfg_done, (i == 5));
         if (i < 5) check("load_out", out, 1'b0);
      end
   endtask

   task automatic run_xor_table();
      for (int i = 0; i < 4; i++) begin
         tin = xor_vec[i].a;
         #1;
         check("xor_out", out, xor_vec[i].exp);
      end
   endtask

   initial begin
      xor_vec[0] = '{2'b01, 1'b0, 1'b1};
      xor_vec[1] = '{2'b11, 1'b0, 1'b0};
      xor_vec[2] = '{2'b10, 1'b0, 1'b1};
      xor_vec[3] = '{2'b00, 1'b0, 1'b0};

      and_vec[0] = '{2'b00, 1'b0, 1'b1};
      and_vec[1] = '{2'b00, 1'b0, 1'b1};
      and_vec[2] = '{2'b00, 1'b0, 1'b1};
      and_vec[3] = '{2'b00, 1'b1, 1'b0};
      and_vec[4] = '{2'b11, 1'b1, 1'b1};
      and_vec[5] = '{2'b11, 1'b0, 1'b1};
      and_vec[6] = '{2'b01, 1'b1, 1'b0};
      and_vec[7] = '{2'b11, 1'b1, 1'b1};

      // Reset state
      reset_n = 1'b0;
      repeat (2) tick();
      check("rst_out", out, 1'b0);
      check("rst_done", cfg_done, 1'b0);
      check("rst_cfg_out", cfg_out, 1'b0);
      reset_n = 1'b1;
      tick();

      // XOR, combinational
      tin = 2'b00;
      load_bits(xor_f, 0, 5);
      check("xor_cfg_out", cfg_out, xor_f[0]);
      run_xor_table();

      // Reconfiguration from XOR with out=1 into AND, registered, init=1
      tin = 2'b01;
      #1;
      check("reconf_pre_out", out, 1'b1);
      load_bits(and_f, 0, 5);
      tin = 2'b00;
      ce = 1'b0;
      check("and_init_out", out, 1'b1);
      for (int i = 0; i < 8; i++) begin
         sb_t e;
         tin = and_vec[i].a;
         ce = and_vec[i].ce;
         e.name = $sformatf("and_vec%0d", i);
         e.exp = and_vec[i].exp;
         sbq.push_back(e);
         tick();
         pop_check(out);
      end

      // Shift and ce together in ACTIVE: the shift wins and q clears
      tin = 2'b11;
      ce = 1'b1;
      cfg_en = 1'b1;
      cfg_in = xor_f[0];
      tick();
      cfg_en = 1'b0;
      ce = 1'b0;
      check("shiftwin_out", out, 1'b0);
      check("shiftwin_done", cfg_done, 1'b0);
      load_bits(xor_f, 1, 3);
      // Old mode bit of the AND frame has reached the chain output
      check("midload_cfg_out", cfg_out, 1'b1);

      // Asynchronous reset mid-load
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_out", out, 1'b0);
      check("async_rst_done", cfg_done, 1'b0);
      check("async_rst_cfg_out", cfg_out, 1'b0);
      tick();
      reset_n = 1'b1;
      tick();

      // Paused fresh XOR load
      tin = 2'b01;
      load_bits(xor_f, 0, 2);
      repeat (10) begin
         tick();
         check("pause_done", cfg_done, 1'b0);
         check("pause_out", out, 1'b0);
      end
      load_bits(xor_f, 3, 5);
      run_xor_table();

      // Reset while ACTIVE
      tin = 2'b01;
      #1;
      check("active_pre_out", out, 1'b1);
      reset_n = 1'b0;
      #1;
      check("active_rst_out", out, 1'b0);
      check("active_rst_done", cfg_done, 1'b0);
      tick();
      reset_n = 1'b1;
      tick();

      // Two-tile chain: tile B frame first, then tile A frame
      begin
         logic [11:0] s;
         logic [5:0]  ma;
         s = {xor_f, nand_f};
         ma = 6'b0;
         for (int n = 0; n < 12; n++) begin
            ch_en = 1'b1;
            ch_in = s[n];
            ma = {s[n], ma[5:1]};
            if (n < 7) begin
               sb_t e;
               e.name = $sformatf("chain_out%0d", n + 1);
               e.exp = ma[0];
               sbq.push_back(e);
            end
            tick();
            if (n < 7) pop_check(a_cfg_out);
            if (n == 5) check("chain_a_mid_done", a_done, 1'b1);
            if (n == 6) check("chain_a_reload_done", a_done, 1'b0);
         end
         ch_en = 1'b0;
         ch_in = 1'b0;
      end
      check("chain_a_done", a_done, 1'b1);
      check("chain_b_done", b_done, 1'b1);
      for (int i = 0; i < 4; i++) begin
         logic [1:0] sel;
         sel = 2'(i);
         ch_sel = sel;
         #1;
         check("chain_a_xor", a_out, ^sel);
         check("chain_b_nand", b_out, ~&sel);
      end

      if (sbq.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", sbq.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cfg_logic_tile.md
# cfg_logic_tile

Parametrised, serially configured logic tile for the FPGA fabric. It is the next generation of the 5-input LUT tile: the LUT width K is a parameter, configuration is loaded through a daisy-chainable scan chain with a load state machine, and the output register gains a clock enable and a configurable init value. Tiles are chained cfg_out to cfg_in, so a tile array loads from a single bitstream pin.

## Interface
- K, default 5: number of LUT inputs, 2 to 6.
- CFG_W (localparam), equal to 2^K+2: configuration bits per tile.
- clock  input  1  fabric clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- cfg_en  input  1  shift enable; cfg_in is shifted in on each edge where cfg_en=1.
- cfg_in  input  1  serial configuration data.
- cfg_out  output  1  serial chain output, equal to cfg[0]; connects to the next tile's cfg_in.
- cfg_done  output  1  high while the tile is in ACTIVE.
- in  input  K  LUT address; in[0] is the LSB.
- ce  input  1  clock enable for the output flip-flop.
- out  output  1  tile output.

## Operation
- Config register layout: cfg[2^K-1:0] is the LUT truth table, indexed by in. cfg[2^K] is the mode bit (0 = combinational, 1 = registered). cfg[2^K+1] is the flip-flop init bit.
- Shift behaviour:
  - On each edge with cfg_en=1: cfg <= {cfg_in, cfg[CFG_W-1:1]}.
  - The stream is sent LSB first. Bit 0 is sent first and the init bit is sent last.
- Bit counter: range 0 to CFG_W-1. It increments on each shift and wraps to 0 on the shift that completes a frame.
- State machine: UNCONFIG, LOAD, ACTIVE.
  - UNCONFIG, cfg_en=1: go to LOAD, count=1.
  - LOAD, cfg_en=1, count<CFG_W-1: stay in LOAD, count+1.
  - LOAD, cfg_en=1, count=CFG_W-1: go to ACTIVE, count=0, q <= cfg_in (the init bit).
  - LOAD, cfg_en=0: stay in LOAD. Count and cfg hold (load is paused).
  - ACTIVE, cfg_en=1: go to LOAD, count=1. This is a reconfiguration; the shift occurs.
  - ACTIVE, cfg_en=0: stay in ACTIVE.
- LUT value: d = cfg[in].
- Flip-flop q:
  - Held at 0 in UNCONFIG and LOAD, except on the completing edge, where it loads the init bit.
  - In ACTIVE: q <= d when ce=1, and holds when ce=0.
- out:
  - 0 whenever state is not ACTIVE.
  - In ACTIVE: equal to d when mode=0, equal to q when mode=1.
- Daisy chain of N tiles: stream N*CFG_W bits, with the last tile's frame first. Each tile's counter passes through ACTIVE at every frame boundary. All tiles end in ACTIVE once the full stream has been shifted. cfg_done is therefore meaningful only after the full stream.

## Timing
- Reset (asynchronous, reset_n=0): cfg=0, state=UNCONFIG, count=0, q=0, out=0, cfg_done=0, cfg_out=0. Reset mid-load discards the partial frame.
- cfg_done rises on the edge that shifts the final (CFG_W-th) bit. It falls on the edge of any shift taken from ACTIVE.
- cfg_out changes on the edge after a shift. It is registered, so there is no combinational path from cfg_in to cfg_out.
- Mode 0: out is combinational from in, with zero-cycle latency.
- Mode 1: out equals the init bit in the first ACTIVE cycle. After that, out reflects d one edge after ce=1.
- ce and in are ignored outside ACTIVE.
- A shift and ce in the same ACTIVE cycle: the shift wins. The tile leaves ACTIVE and q is cleared to 0.

## Test plan
Tests use K=2, so CFG_W=6.
- XOR, combinational: stream 0,1,1,0,0,0 -> cfg_done=1 after the 6th edge. Then in=01 -> out=1; in=11 -> out=0, both in the same cycle.
- AND, registered, init=1: stream 0,0,0,1,1,1 -> out=1 at the first ACTIVE cycle.
  - ce=0 with in=00 for 3 cycles -> out stays 1.
  - ce=1 -> out=0 after one edge.
  - in=11, ce=1 -> out=1 after one edge.
- Paused load: shift 3 bits, hold cfg_en=0 for 10 cycles, then shift the remaining 3 -> cfg_done rises only on the 6th shift, and the result matches the unpaused load. out=0 throughout the load.
- Reset mid-operation:
  - Assert reset_n=0 after 4 shifts -> out, cfg_done and cfg_out are 0 immediately, without waiting for a clock edge.
  - A fresh 6-bit load then succeeds.
  - Reset while ACTIVE also clears the tile.
- Reconfiguration: from ACTIVE XOR with out=1, assert cfg_en -> cfg_done=0 and out=0 from that edge. Loading AND yields AND behaviour.
- Two-tile chain: stream 12 bits (tile B's frame, then tile A's) into A.cfg_in, with A.cfg_out wired to B.cfg_in -> both cfg_done=1 and both tiles implement their own truth tables. Check A.cfg_out for the expected serial data after each of the first 7 shifts.
